// File: rtl/puf_seed_collector_pkg.sv
// puf_seed_collector_pkg: shared FSM states, default seed/pass sizes and vote-counter width helper
package puf_seed_collector_pkg;
  localparam int DEFAULT_NUM_BITS  = 32;
  localparam int DEFAULT_NUM_READS = 5;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VOTE    = 3'd2,
    CHECK   = 3'd3,
    LOAD    = 3'd4,
    RUN     = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;
  function automatic int vote_cnt_width(input int num_reads);
    return $clog2(num_reads + 1);
  endfunction
endpackage

// File: rtl/puf_vote_bank.sv
// puf_vote_bank: per-bit vote counters, registered majority seed and unstable-bit count
// Ports: i_Clk/i_Reset; clr zeroes counters, inc adds puf_bit into counter[bit_idx];
// vote latches seed_data (majority) and unstable_count (only with PUF_STABILITY_CHECK_EN, else 0).
module puf_vote_bank
  import puf_seed_collector_pkg::*;
#(
  parameter int  NUM_BITS  = DEFAULT_NUM_BITS,
  parameter int  NUM_READS = DEFAULT_NUM_READS,
  localparam int BW        = $clog2(NUM_BITS),
  localparam int UW        = $clog2(NUM_BITS + 1)
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                clr,
  input  logic                inc,
  input  logic [BW-1:0]       bit_idx,
  input  logic                puf_bit,
  input  logic                vote,
  output logic [NUM_BITS-1:0] seed_data,
  output logic [UW-1:0]       unstable_count
);
  localparam int CW = vote_cnt_width(NUM_READS);
  logic [CW-1:0]       cnt [NUM_BITS];
  logic [NUM_BITS-1:0] maj;
  always_ff @(posedge i_Clk)
    if (i_Reset || clr) cnt <= '{default: '0};
    else if (inc) cnt[bit_idx] <= cnt[bit_idx] + CW'(puf_bit);
  for (genvar j = 0; j < NUM_BITS; j++) begin : g_maj
    assign maj[j] = cnt[j] > CW'(NUM_READS / 2);
  end
  always_ff @(posedge i_Clk)
    if (i_Reset) seed_data <= '0;
    else if (vote) seed_data <= maj;
`ifdef PUF_STABILITY_CHECK_EN
  logic [UW-1:0] unst_n;
  always_comb begin
    unst_n = '0;
    for (int j = 0; j < NUM_BITS; j++)
      unst_n = unst_n + UW'(cnt[j] != '0 && cnt[j] != CW'(NUM_READS));
  end
  always_ff @(posedge i_Clk)
    if (i_Reset) unstable_count <= '0;
    else if (vote) unstable_count <= unst_n;
`else
  assign unstable_count = '0;
`endif
endmodule

// File: rtl/puf_seed_collector.sv
// puf_seed_collector: collects NUM_READS serial PUF passes, majority-votes a seed and hands it to an LFSR stage
// Ports: i_Clk/i_Reset (sync, active-high); i_Start; PUF stream i_Puf_Valid/i_Puf_Bit/o_Puf_Ready;
// o_Seed_Data; LFSR handshake o_Lfsr_Enable/o_Lfsr_Reset/i_Lfsr_Done; status o_Done/o_Error/o_Unstable_Count.
// Build option PUF_STABILITY_CHECK_EN enables o_Unstable_Count (tied 0 otherwise).
module puf_seed_collector
  import puf_seed_collector_pkg::*;
#(
  parameter int NUM_BITS  = DEFAULT_NUM_BITS,
  parameter int NUM_READS = DEFAULT_NUM_READS
) (
  input  logic                             i_Clk,
  input  logic                             i_Reset,
  input  logic                             i_Start,
  input  logic                             i_Puf_Valid,
  input  logic                             i_Puf_Bit,
  output logic                             o_Puf_Ready,
  output logic [NUM_BITS-1:0]              o_Seed_Data,
  output logic                             o_Lfsr_Enable,
  output logic                             o_Lfsr_Reset,
  input  logic                             i_Lfsr_Done,
  output logic                             o_Done,
  output logic                             o_Error,
  output logic [$clog2(NUM_BITS+1)-1:0]    o_Unstable_Count
);
  localparam int BW = $clog2(NUM_BITS);
  localparam int PW = $clog2(NUM_READS);
  state_t        state, state_n;
  logic [BW-1:0] bit_idx;
  logic [PW-1:0] pass_idx;
  logic          start, xfer, bit_wrap, last;
  assign start    = i_Start && (state == IDLE || state == DONE || state == ERROR);
  assign xfer     = i_Puf_Valid && o_Puf_Ready;
  assign bit_wrap = bit_idx == BW'(NUM_BITS - 1);
  assign last     = bit_wrap && pass_idx == PW'(NUM_READS - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = i_Start ? COLLECT : state;
      COLLECT:           state_n = xfer && last ? VOTE : COLLECT;
      VOTE:              state_n = CHECK;
      CHECK:             state_n = &o_Seed_Data ? ERROR : LOAD;
      LOAD:              state_n = RUN;
      RUN:               state_n = i_Lfsr_Done ? DONE : RUN;
      default:           state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      state    <= IDLE;
      bit_idx  <= '0;
      pass_idx <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        bit_idx  <= '0;
        pass_idx <= '0;
      end else if (xfer) begin
        bit_idx  <= bit_wrap ? '0 : bit_idx + BW'(1);
        pass_idx <= bit_wrap ? pass_idx + PW'(1) : pass_idx;
      end
    end
  assign o_Puf_Ready   = state == COLLECT;
  assign o_Lfsr_Enable = state == LOAD || state == RUN;
  assign o_Lfsr_Reset  = state == LOAD;
  assign o_Done        = state == DONE;
  assign o_Error       = state == ERROR;
  puf_vote_bank #(.NUM_BITS(NUM_BITS), .NUM_READS(NUM_READS)) u_vote_bank (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .clr           (start),
    .inc           (xfer),
    .bit_idx       (bit_idx),
    .puf_bit       (i_Puf_Bit),
    .vote          (state == VOTE),
    .seed_data     (o_Seed_Data),
    .unstable_count(o_Unstable_Count)
  );
endmodule

// File: tb/tb_puf_seed_collector.sv
// tb_puf_seed_collector: randomized self-checking bench for puf_seed_collector against a bitwise majority model
module tb_puf_seed_collector;
  localparam int NB = 32;
  localparam int NR = 5;
  typedef logic [NB-1:0] passes_t [NR];
  logic          clk = 0;
  logic          i_Reset = 1, i_Start = 0, i_Puf_Valid = 0, i_Puf_Bit = 0, i_Lfsr_Done = 0;
  logic          o_Puf_Ready, o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Error;
  logic [NB-1:0] o_Seed_Data;
  logic [5:0]    o_Unstable_Count;
  int            checks = 0, failures = 0;
  always #5 clk = ~clk;
  puf_seed_collector dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Puf_Valid(i_Puf_Valid), .i_Puf_Bit(i_Puf_Bit),
    .o_Puf_Ready(o_Puf_Ready), .o_Seed_Data(o_Seed_Data), .o_Lfsr_Enable(o_Lfsr_Enable),
    .o_Lfsr_Reset(o_Lfsr_Reset), .i_Lfsr_Done(i_Lfsr_Done), .o_Done(o_Done), .o_Error(o_Error),
    .o_Unstable_Count(o_Unstable_Count)
  );
  function automatic void model(input passes_t w, output logic [NB-1:0] seed, output int unst);
    seed = '0;
    unst = 0;
    for (int j = 0; j < NB; j++) begin
      int ones;
      ones = 0;
      for (int p = 0; p < NR; p++) ones += int'(w[p][j]);
      seed[j] = 2 * ones > NR;
      if (ones > 0 && ones < NR) unst++;
    end
`ifndef PUF_STABILITY_CHECK_EN
    unst = 0;
`endif
  endfunction
  function automatic passes_t random_passes();
    passes_t w;
    logic [NB-1:0] base;
    base = $urandom & 32'h7FFF_FFFF;
    for (int p = 0; p < NR; p++) w[p] = base ^ ($urandom & $urandom & $urandom & 32'h7FFF_FFFF);
    return w;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    i_Reset = 1; i_Start = 0; i_Puf_Valid = 0; i_Lfsr_Done = 0;
    @(negedge clk);
    i_Reset = 0;
  endtask
  task automatic start_run();
    i_Start = 1;
    @(negedge clk);
    i_Start = 0;
  endtask
  task automatic collect(input passes_t w, input int gap, input int n, output int xfers);
    logic v, r;
    int waited;
    xfers = 0;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      forever begin
        v = $urandom_range(99) >= gap;
        i_Puf_Valid = v;
        i_Puf_Bit = v ? w[k / NB][k % NB] : 1'($urandom);
        r = o_Puf_Ready;
        @(negedge clk);
        if (v && r) begin
          xfers++;
          break;
        end
        if (++waited > 200) begin
          checks++; failures++;
          $display("FAIL collect_timeout transfers=%0d required=%0d", xfers, n);
          i_Puf_Valid = 0;
          return;
        end
      end
    end
    i_Puf_Valid = 0;
  endtask
  task automatic observe(output logic [NB-1:0] seed, output logic [5:0] un, output int loads,
                         output int load_at, output bit en_seen, output bit err_seen);
    seed = '0; un = '0; loads = 0; load_at = 0; en_seen = 0; err_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        seed = o_Seed_Data;
        un = o_Unstable_Count;
      end
      if (o_Lfsr_Reset) begin
        loads++;
        if (load_at == 0) load_at = k;
      end
      en_seen |= o_Lfsr_Enable;
      err_seen |= o_Error;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks += 3;
    if ({o_Puf_Ready, o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Error} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b required=00000", {o_Puf_Ready, o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Error});
    end
    if (o_Seed_Data !== '0) begin failures++; $display("FAIL reset_seed got=%h required=0", o_Seed_Data); end
    if (o_Unstable_Count !== '0) begin failures++; $display("FAIL reset_unstable got=%0d required=0", o_Unstable_Count); end
  endtask
  task automatic test_a5();
    passes_t w;
    logic [NB-1:0] seed, es;
    logic [5:0] un;
    int x, loads, load_at, eu;
    bit en, er;
    for (int p = 0; p < NR; p++) w[p] = 32'hA5A5_A5A5;
    model(w, es, eu);
    do_reset(); start_run(); collect(w, 0, 160, x); observe(seed, un, loads, load_at, en, er);
    checks += 6;
    if (x !== 160) begin failures++; $display("FAIL a5_transfers got=%0d required=160", x); end
    if (seed !== 32'hA5A5_A5A5) begin failures++; $display("FAIL a5_seed got=%h required=a5a5a5a5", seed); end
    if (seed !== es) begin failures++; $display("FAIL a5_model got=%h required=%h", seed, es); end
    if (loads !== 1) begin failures++; $display("FAIL a5_load_count got=%0d required=1", loads); end
    if (load_at !== 3) begin failures++; $display("FAIL a5_load_latency got=%0d required=3", load_at); end
    if (un !== 6'd0) begin failures++; $display("FAIL a5_unstable got=%0d required=0", un); end
  endtask
  task automatic test_flip();
    passes_t w;
    logic [NB-1:0] seed, es;
    logic [5:0] un;
    int x, loads, load_at, eu;
    bit en, er;
    for (int p = 0; p < NR; p++) w[p] = 32'h1234_5678 ^ NB'(p < 2);
    model(w, es, eu);
    do_reset(); start_run(); collect(w, 0, 160, x); observe(seed, un, loads, load_at, en, er);
    checks += 3;
    if (seed !== 32'h1234_5678) begin failures++; $display("FAIL flip_seed got=%h required=12345678", seed); end
    if (un !== 6'(eu)) begin failures++; $display("FAIL flip_unstable got=%0d required=%0d", un, eu); end
    if (loads !== 1) begin failures++; $display("FAIL flip_load_count got=%0d required=1", loads); end
  endtask
  task automatic test_error();
    passes_t w;
    logic [NB-1:0] seed;
    logic [5:0] un;
    int x, loads, load_at;
    bit en, er;
    for (int p = 0; p < NR; p++) w[p] = '1;
    do_reset(); start_run(); collect(w, 0, 160, x); observe(seed, un, loads, load_at, en, er);
    checks += 5;
    if (er !== 1'b1 || o_Error !== 1'b1) begin failures++; $display("FAIL err_flag got=%b/%b required=1/1", er, o_Error); end
    if (en !== 1'b0) begin failures++; $display("FAIL err_enable got=%b required=0", en); end
    if (loads !== 0) begin failures++; $display("FAIL err_loads got=%0d required=0", loads); end
    start_run();
    if (o_Puf_Ready !== 1'b1) begin failures++; $display("FAIL err_restart_ready got=%b required=1", o_Puf_Ready); end
    if (o_Error !== 1'b0) begin failures++; $display("FAIL err_restart_error got=%b required=0", o_Error); end
  endtask
  task automatic test_gaps();
    passes_t w;
    logic [NB-1:0] s0, s1, es;
    logic [5:0] u0, u1;
    int x0, x1, loads, load_at, eu;
    bit en, er;
    w = random_passes();
    model(w, es, eu);
    do_reset(); start_run(); collect(w, 0, 160, x0); observe(s0, u0, loads, load_at, en, er);
    do_reset();
    i_Lfsr_Done = 1;
    start_run(); collect(w, 50, 160, x1);
    i_Lfsr_Done = 0;
    observe(s1, u1, loads, load_at, en, er);
    checks += 6;
    if (s0 !== es) begin failures++; $display("FAIL gap0_seed got=%h required=%h", s0, es); end
    if (x1 !== 160) begin failures++; $display("FAIL gap_transfers got=%0d required=160", x1); end
    if (s1 !== es) begin failures++; $display("FAIL gap_seed got=%h required=%h", s1, es); end
    if (s1 !== s0) begin failures++; $display("FAIL gap_vs_nogap got=%h required=%h", s1, s0); end
    if (u1 !== 6'(eu)) begin failures++; $display("FAIL gap_unstable got=%0d required=%0d", u1, eu); end
    if (load_at !== 3) begin failures++; $display("FAIL gap_load_latency got=%0d required=3", load_at); end
  endtask
  task automatic test_run_done();
    passes_t w;
    logic [NB-1:0] seed, es;
    logic [5:0] un;
    int x, loads, load_at, eu;
    bit en, er;
    w = random_passes();
    model(w, es, eu);
    do_reset(); start_run(); collect(w, 0, 160, x); observe(seed, un, loads, load_at, en, er);
    for (int i = 0; i < 250; i++) begin
      checks++;
      if ({o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Puf_Ready} !== 4'b1000) begin
        failures++; $display("FAIL run_hold cycle=%0d got=%b required=1000", i, {o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Puf_Ready});
      end
      i_Start = 1'($urandom);
      @(negedge clk);
    end
    i_Start = 0;
    i_Lfsr_Done = 1;
    @(negedge clk);
    i_Lfsr_Done = 0;
    checks += 3;
    if (o_Done !== 1'b1) begin failures++; $display("FAIL run_done got=%b required=1", o_Done); end
    if ({o_Lfsr_Enable, o_Lfsr_Reset} !== 2'b00) begin failures++; $display("FAIL run_done_lfsr got=%b required=00", {o_Lfsr_Enable, o_Lfsr_Reset}); end
    if (o_Seed_Data !== es) begin failures++; $display("FAIL run_seed_held got=%h required=%h", o_Seed_Data, es); end
    @(negedge clk);
    checks++;
    if (o_Done !== 1'b1) begin failures++; $display("FAIL done_hold got=%b required=1", o_Done); end
  endtask
  task automatic test_reset_midrun();
    passes_t w;
    logic [NB-1:0] seed, es;
    logic [5:0] un;
    int x, loads, load_at, eu;
    bit en, er;
    w = random_passes();
    model(w, es, eu);
    start_run(); collect(w, 0, 70, x);
    i_Reset = 1; i_Start = 1;
    @(negedge clk);
    i_Reset = 0; i_Start = 0;
    checks += 4;
    if (x !== 70) begin failures++; $display("FAIL mid_transfers got=%0d required=70", x); end
    if ({o_Puf_Ready, o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Error} !== 5'b0) begin
      failures++; $display("FAIL mid_reset_flags got=%b required=00000", {o_Puf_Ready, o_Lfsr_Enable, o_Lfsr_Reset, o_Done, o_Error});
    end
    if (o_Seed_Data !== '0 || o_Unstable_Count !== '0) begin
      failures++; $display("FAIL mid_reset_data got=%h/%0d required=0/0", o_Seed_Data, o_Unstable_Count);
    end
    @(negedge clk);
    if (o_Puf_Ready !== 1'b0) begin failures++; $display("FAIL mid_idle_hold got=%b required=0", o_Puf_Ready); end
    start_run(); collect(w, 0, 160, x); observe(seed, un, loads, load_at, en, er);
    checks += 2;
    if (seed !== es) begin failures++; $display("FAIL mid_fresh_seed got=%h required=%h", seed, es); end
    if (loads !== 1) begin failures++; $display("FAIL mid_fresh_loads got=%0d required=1", loads); end
  endtask
  initial begin
    test_reset();
    test_a5();
    test_flip();
    test_error();
    test_gaps();
    test_run_done();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
